key_search_scheduler: RTL and testbench
=======================================

# key_search_scheduler

Multi-core key-search scheduler for the RC4 breaker. It hands out consecutive candidate secret keys from 0 to MAX_KEY to NUM_CORES independent decrypt/validate cores, using a round-robin grant over idle cores. It collects each core's verdict and stops the search on the first valid key, reporting that key and the core that found it. It sits between the top-level control FSM and the replicated decryption_core/validator pairs.

## Interface
Parameters:
- NUM_CORES, default 4: number of decrypt/validate cores, range 1..8.
- KEY_WIDTH, default 22: width of the searched key space.
- MAX_KEY, default 2^KEY_WIDTH-1: last key issued, inclusive.

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a search; honoured only in IDLE.
- core_done  in  NUM_CORES  per-core pulse: candidate finished.
- core_found  in  NUM_CORES  per-core verdict; meaningful only when the same bit of core_done is 1.
- core_start  out  NUM_CORES  one-hot one-cycle pulse that launches a core.
- core_key  out  KEY_WIDTH  candidate key; valid when any core_start bit is 1.
- core_abort  out  1  one-cycle pulse telling all cores to stop.
- busy  out  1  high in RUN and DRAIN.
- found  out  1  sticky; a valid key was found.
- exhausted  out  1  sticky; all keys were tried and none was valid.
- found_key  out  KEY_WIDTH  the winning key.
- found_core  out  3  index of the winning core.
- keys_issued  out  KEY_WIDTH+1  count of keys dispatched in the current search.

## Operation
- States: IDLE, RUN, DRAIN, FOUND, EXHAUSTED.
- IDLE → RUN on start. On this transition: next_key=0, keys_issued=0, core_busy=0, rr_ptr=0.
- RUN, dispatch rule:
  - Applies when next_key ≤ MAX_KEY and at least one core_busy bit is 0.
  - Grant the first idle core at or after rr_ptr, searching circularly.
  - Assert core_start[g] with core_key=next_key.
  - Set key_reg[g]=next_key and core_busy[g]=1.
  - Increment next_key and keys_issued; set rr_ptr=(g+1) mod NUM_CORES.
  - At most one dispatch per cycle.
- Completion: core_done[i] with core_busy[i]=1 clears core_busy[i].
  - The cleared core becomes grantable the next cycle, not the same cycle.
  - core_done[i] with core_busy[i]=0 is ignored, including any core_found with it.
- Hit: core_done[i] & core_found[i] & core_busy[i].
  - Latch found_key=key_reg[i] and found_core=i.
  - Pulse core_abort; go to FOUND.
  - No dispatch is issued in a hit cycle; a hit has priority over dispatch.
  - Simultaneous hits: the lowest index wins.
- next_key is KEY_WIDTH+1 bits wide so that MAX_KEY=2^KEY_WIDTH-1 cannot wrap.
  - Once next_key>MAX_KEY, go to DRAIN.
- DRAIN: no dispatch. Hits are handled as in RUN and go to FOUND. When core_busy==0 with no hit, go to EXHAUSTED.
- FOUND and EXHAUSTED are terminal until reset. start is ignored in them, and in RUN and DRAIN.
- found and exhausted are never high together.

## Timing
- Reset values:
  - core_start=0, core_key=0, core_abort=0, busy=0.
  - found=0, exhausted=0, found_key=0, found_core=0, keys_issued=0.
  - State=IDLE, core_busy=0.
- All outputs are registered.
- The first core_start is asserted 2 cycles after the start pulse is sampled: 1 cycle to enter RUN, 1 cycle for the registered grant.
- Peak throughput: 1 dispatch per cycle while cores are idle.
- Latency from hit to found: found rises the cycle after the hit is sampled, together with the core_abort pulse.
- EXHAUSTED is reached the cycle after the last busy core's core_done is sampled.
- Reset mid-search: all state clears on the next edge. No core_start or core_abort is produced in the reset cycle.

## Test plan
With NUM_CORES=4 and MAX_KEY=7 unless stated otherwise:
- **Startup dispatch:** start, all cores idle → core_start = 0001, 0010, 0100, 1000 on 4 consecutive cycles with core_key = 0,1,2,3; keys_issued=4; busy=1.
- **Round-robin refill and exhaustion:** pulse core_done[2] (found=0), then core_done[0] → the next grants go to core 2 with key 4, then core 0 with key 5; all later dones have found=0 → exhausted=1 after the last done, keys_issued=8, found=0.
- **Hit:** core 1 (holding key 5) returns done+found → the next cycle found=1, found_key=5, found_core=1, core_abort pulses once, and no core_start follows.
- **Simultaneous hits:** cores 3 and 1 report done+found in the same cycle → found_core=1 and found_key=key_reg[1].
- **Spurious done:** core_done[0]+core_found[0] while core 0 is idle → ignored; found stays 0 and the search continues.
- **Boundary and reset:** with NUM_CORES=1 and MAX_KEY=2^22-1, reset mid-RUN → all outputs are 0 and the state is IDLE on the next cycle. Separately, force next_key=MAX_KEY: that key is issued once, then the block enters DRAIN with no wrap to 0.

Source files
------------

// File: rtl/key_search_scheduler.sv
// key_search_scheduler
//   Hands out consecutive candidate keys 0..MAX_KEY to NUM_CORES decrypt /
//   validate cores using a round-robin grant over idle cores, collects each
//   core's verdict and stops on the first valid key.
//
// Handshake: a core is launched by a one-cycle core_start[g] pulse with
//   core_key valid in the same cycle. It answers with a one-cycle
//   core_done[g] pulse, and core_found[g] is the verdict sampled only in that
//   cycle. A done from a core the scheduler does not consider busy is ignored.
//   The cleared core can be granted again on the following cycle.
//
// Ports:
//   CLOCK_50     in   system clock (rising edge)
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle pulse, begins a search (IDLE only)
//   core_done    in   per-core completion pulse
//   core_found   in   per-core verdict, qualified by core_done
//   core_start   out  one-hot launch pulse
//   core_key     out  candidate key for the launched core
//   core_abort   out  one-cycle pulse, stop all cores
//   busy         out  high while searching (RUN / DRAIN)
//   found        out  sticky, a valid key was found
//   exhausted    out  sticky, all keys tried without a hit
//   found_key    out  winning key
//   found_core   out  index of the winning core
//   keys_issued  out  keys dispatched in this search
//   dbg_state    out  FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 FOUND, 4 EXHAUSTED)
module key_search_scheduler #(
  parameter int              NUM_CORES = 4,
  parameter int              KEY_WIDTH = 22,
  parameter longint unsigned MAX_KEY   = (64'd1 << KEY_WIDTH) - 64'd1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_found,
  output logic [NUM_CORES-1:0] core_start,
  output logic [KEY_WIDTH-1:0] core_key,
  output logic                 core_abort,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic [2:0]           found_core,
  output logic [KEY_WIDTH:0]   keys_issued,
  output logic [2:0]           dbg_state
);

  localparam logic [KEY_WIDTH:0] P_MAX = MAX_KEY[KEY_WIDTH:0];

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_DRAIN     = 3'd2,
    S_FOUND     = 3'd3,
    S_EXHAUSTED = 3'd4
  } state_t;

  state_t                 r_state;
  // One bit wider than the key so that MAX_KEY = 2^KEY_WIDTH-1 cannot wrap.
  logic [KEY_WIDTH:0]     r_next_key;
  logic [NUM_CORES-1:0]   r_core_busy;
  logic [2:0]             r_rr_ptr;
  // Sized for the maximum core count so every index is a plain 3-bit value;
  // entries above NUM_CORES-1 are never written.
  logic [KEY_WIDTH-1:0]   r_key_reg [8];
  logic [NUM_CORES-1:0]   r_core_start;
  logic [KEY_WIDTH-1:0]   r_core_key;
  logic                   r_core_abort;
  logic                   r_busy;
  logic                   r_found;
  logic                   r_exhausted;
  logic [KEY_WIDTH-1:0]   r_found_key;
  logic [2:0]             r_found_core;

  logic [NUM_CORES-1:0]   w_done_valid;
  logic [NUM_CORES-1:0]   w_busy_after_done;
  logic [7:0]             w_busy8;
  logic [7:0]             w_hit8;
  logic [7:0]             w_grant8;
  logic                   w_hit;
  logic [2:0]             w_hit_idx;
  logic                   w_grant_ok;
  logic [2:0]             w_grant_idx;
  logic [2:0]             w_rr_next;
  logic                   w_dispatch;
  int                     w_c;

  always_comb begin
    w_done_valid      = core_done & r_core_busy;
    w_busy_after_done = r_core_busy & ~w_done_valid;
    // Non-existent cores read as busy so they are never granted.
    w_busy8                = '1;
    w_busy8[NUM_CORES-1:0] = r_core_busy;
    w_hit8                 = '0;
    w_hit8[NUM_CORES-1:0]  = w_done_valid & core_found;
    w_hit                  = |w_hit8;

    // Descending scan so the lowest hitting index is the one left standing.
    w_hit_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_hit8[i]) w_hit_idx = 3'(i);
    end

    // Circular search from r_rr_ptr; scanned backwards so the nearest idle
    // core at or after the pointer wins. Uses the registered busy vector, so
    // a core finishing this cycle is only grantable next cycle.
    w_grant_ok  = ~&w_busy8;
    w_grant_idx = 3'd0;
    w_c         = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      w_c = int'(r_rr_ptr) + k;
      if (w_c >= NUM_CORES) w_c = w_c - NUM_CORES;
      if (!w_busy8[3'(w_c)]) w_grant_idx = 3'(w_c);
    end

    w_rr_next  = (int'(w_grant_idx) == NUM_CORES - 1) ? 3'd0 : w_grant_idx + 3'd1;
    w_grant8   = 8'd1 << w_grant_idx;
    w_dispatch = (r_state == S_RUN) && !w_hit && w_grant_ok && (r_next_key <= P_MAX);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_next_key   <= '0;
      r_core_busy  <= '0;
      r_rr_ptr     <= '0;
      for (int i = 0; i < 8; i++) r_key_reg[i] <= '0;
      r_core_start <= '0;
      r_core_key   <= '0;
      r_core_abort <= 1'b0;
      r_busy       <= 1'b0;
      r_found      <= 1'b0;
      r_exhausted  <= 1'b0;
      r_found_key  <= '0;
      r_found_core <= '0;
    end else begin
      r_core_start <= '0;
      r_core_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_next_key  <= '0;
            r_core_busy <= '0;
            r_rr_ptr    <= '0;
            r_busy      <= 1'b1;
          end
        end
        S_RUN, S_DRAIN: begin
          r_core_busy <= w_busy_after_done | (w_dispatch ? w_grant8[NUM_CORES-1:0] : '0);
          if (w_hit) begin
            r_state      <= S_FOUND;
            r_found      <= 1'b1;
            r_found_key  <= r_key_reg[w_hit_idx];
            r_found_core <= w_hit_idx;
            r_core_abort <= 1'b1;
            r_busy       <= 1'b0;
          end else if (w_dispatch) begin
            r_core_start           <= w_grant8[NUM_CORES-1:0];
            r_core_key             <= r_next_key[KEY_WIDTH-1:0];
            r_key_reg[w_grant_idx] <= r_next_key[KEY_WIDTH-1:0];
            r_next_key             <= r_next_key + 1'b1;
            r_rr_ptr               <= w_rr_next;
            if (r_next_key == P_MAX) r_state <= S_DRAIN;
          end else if (r_state == S_RUN && r_next_key > P_MAX) begin
            r_state <= S_DRAIN;
          end else if (r_state == S_DRAIN && w_busy_after_done == '0) begin
            // The last outstanding core finished this cycle without a hit.
            r_state     <= S_EXHAUSTED;
            r_exhausted <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: ; // FOUND and EXHAUSTED hold until reset
      endcase
    end
  end

  assign core_start  = r_core_start;
  assign core_key    = r_core_key;
  assign core_abort  = r_core_abort;
  assign busy        = r_busy;
  assign found       = r_found;
  assign exhausted   = r_exhausted;
  assign found_key   = r_found_key;
  assign found_core  = r_found_core;
  assign keys_issued = r_next_key;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Testbench for key_search_scheduler: a 4-core / 3-bit-key instance checked
// cycle by cycle against a behavioural model, plus a 1-core / 22-bit instance
// for reset-mid-search checks.
module tb_key_search_scheduler;

  localparam int N  = 4;
  localparam int KW = 3;
  localparam int MK = 7;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2, ST_FOUND = 3, ST_EXH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start;
  logic [N-1:0]  done, fnd;
  logic [N-1:0]  core_start;
  logic [KW-1:0] core_key, found_key;
  logic          core_abort, busy, found, exhausted;
  logic [2:0]    found_core, dbg_state;
  logic [KW:0]   keys_issued;

  key_search_scheduler #(.NUM_CORES(N), .KEY_WIDTH(KW), .MAX_KEY(MK)) u_dut (
    .CLOCK_50(clk), .reset(rst), .start(start),
    .core_done(done), .core_found(fnd),
    .core_start(core_start), .core_key(core_key), .core_abort(core_abort),
    .busy(busy), .found(found), .exhausted(exhausted),
    .found_key(found_key), .found_core(found_core),
    .keys_issued(keys_issued), .dbg_state(dbg_state)
  );

  logic        b_rst, b_start;
  logic [0:0]  b_done, b_fnd, b_core_start;
  logic [21:0] b_core_key, b_found_key;
  logic        b_core_abort, b_busy, b_found, b_exhausted;
  logic [2:0]  b_found_core, b_dbg_state;
  logic [22:0] b_keys_issued;

  key_search_scheduler #(.NUM_CORES(1), .KEY_WIDTH(22)) u_big (
    .CLOCK_50(clk), .reset(b_rst), .start(b_start),
    .core_done(b_done), .core_found(b_fnd),
    .core_start(b_core_start), .core_key(b_core_key), .core_abort(b_core_abort),
    .busy(b_busy), .found(b_found), .exhausted(b_exhausted),
    .found_key(b_found_key), .found_core(b_found_core),
    .keys_issued(b_keys_issued), .dbg_state(b_dbg_state)
  );

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // behavioural reference model
  int m_state, m_next, m_rr;
  bit m_busy [N];
  int m_key  [N];
  int e_start, e_key, e_abort, e_found, e_exh, e_fkey, e_fcore;

  task automatic m_reset();
    m_state = ST_IDLE; m_next = 0; m_rr = 0;
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_key[i] = 0; end
    e_start = 0; e_key = 0; e_abort = 0; e_found = 0; e_exh = 0; e_fkey = 0; e_fcore = 0;
  endtask

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic m_step(input logic st, input logic [N-1:0] d, input logic [N-1:0] f);
    int  hit, g, c;
    bit  was_drain;
    e_start = 0;
    e_abort = 0;
    if (m_state == ST_IDLE) begin
      if (st) begin
        m_state = ST_RUN; m_next = 0; m_rr = 0;
        for (int i = 0; i < N; i++) m_busy[i] = 0;
      end
    end else if (m_state == ST_RUN || m_state == ST_DRAIN) begin
      was_drain = (m_state == ST_DRAIN);
      hit = -1;
      for (int i = 0; i < N; i++) if (hit < 0 && d[i] && f[i] && m_busy[i]) hit = i;
      g = -1;
      if (!was_drain && hit < 0 && m_next <= MK)
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (g < 0 && !m_busy[c]) g = c;
        end
      for (int i = 0; i < N; i++) if (d[i]) m_busy[i] = 0;
      if (hit >= 0) begin
        m_state = ST_FOUND; e_found = 1; e_fkey = m_key[hit]; e_fcore = hit; e_abort = 1;
      end else begin
        if (g >= 0) begin
          e_start = 1 << g; e_key = m_next; m_key[g] = m_next; m_busy[g] = 1;
          m_next++; m_rr = (g + 1) % N;
          if (m_next > MK) m_state = ST_DRAIN;
        end
        if (was_drain && busy_count() == 0) begin
          m_state = ST_EXH; e_exh = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":core_start"}, 32'(core_start), e_start);
    if (e_start != 0) chk({tag, ":core_key"}, 32'(core_key), e_key);
    chk({tag, ":core_abort"},  32'(core_abort),  e_abort);
    chk({tag, ":busy"},        32'(busy), (m_state == ST_RUN || m_state == ST_DRAIN) ? 1 : 0);
    chk({tag, ":found"},       32'(found),       e_found);
    chk({tag, ":exhausted"},   32'(exhausted),   e_exh);
    chk({tag, ":found_key"},   32'(found_key),   e_fkey);
    chk({tag, ":found_core"},  32'(found_core),  e_fcore);
    chk({tag, ":keys_issued"}, 32'(keys_issued), m_next);
    chk({tag, ":state"},       32'(dbg_state),   m_state);
  endtask

  // driver tasks
  task automatic step(input string tag, input logic st, input logic [N-1:0] d, input logic [N-1:0] f);
    start = st; done = d; fnd = f;
    m_step(st, d, f);
    @(posedge clk); #1;
    start = 1'b0; done = '0; fnd = '0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; start = 1'b0; done = '0; fnd = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    check_all(tag);
  endtask

  task automatic run_random(input string tag, input int hit_odds, input int spur_odds, input int limit);
    int n;
    logic [N-1:0] d, f;
    n = 0;
    while (!(m_state == ST_FOUND || m_state == ST_EXH) && n < limit) begin
      d = '0; f = '0;
      for (int i = 0; i < N; i++) begin
        if (m_busy[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            d[i] = 1'b1;
            if (hit_odds > 0 && $urandom_range(1, hit_odds) == 1) f[i] = 1'b1;
          end
        end else if (spur_odds > 0 && $urandom_range(1, spur_odds) == 1) begin
          d[i] = 1'b1;
          f[i] = 1'($urandom_range(0, 1));
        end
      end
      step(tag, 1'($urandom_range(0, 1)), d, f);
      n++;
    end
    chk({tag, ":terminated"}, 32'(n < limit), 1);
    // terminal states ignore start and dones
    for (int j = 0; j < 3; j++) step({tag, ":hold"}, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
  endtask

  task automatic tick_big();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; done = '0; fnd = '0;
    b_rst = 1'b1; b_start = 1'b0; b_done = '0; b_fnd = '0;
    m_reset();

    // reset state
    do_reset("reset");
    chk("reset_found_zero", 32'(found), 0);

    // startup dispatch, refill order and exhaustion
    step("start", 1'b1, '0, '0);
    for (int i = 0; i < 4; i++) step("startup", 1'b0, '0, '0);
    chk("startup_keys_issued", 32'(keys_issued), 4);
    step("done2", 1'b0, 4'b0100, 4'b0000);
    step("done0", 1'b0, 4'b0001, 4'b0000);
    chk("refill_core2", 32'(core_start), 32'b0100);
    chk("refill_key4",  32'(core_key), 4);
    step("refill", 1'b0, '0, '0);
    chk("refill_core0", 32'(core_start), 32'b0001);
    chk("refill_key5",  32'(core_key), 5);
    run_random("exhaust", 0, 6, 200);
    chk("exh_flag", 32'(exhausted), 1);
    chk("exh_keys", 32'(keys_issued), 8);
    chk("exh_not_found", 32'(found), 0);

    // hit on core 1 holding key 5
    do_reset("reset2");
    step("start", 1'b1, '0, '0);
    for (int i = 0; i < 4; i++) step("fill", 1'b0, '0, '0);
    step("hit_d0", 1'b0, 4'b0001, 4'b0000);
    step("hit_g0", 1'b0, '0, '0);
    step("hit_d1", 1'b0, 4'b0010, 4'b0000);
    step("hit_g1", 1'b0, '0, '0);
    chk("hit_setup_key5", 32'(core_key), 5);
    step("hit", 1'b0, 4'b0010, 4'b0010);
    chk("hit_found_key", 32'(found_key), 5);
    chk("hit_found_core", 32'(found_core), 1);
    chk("hit_abort", 32'(core_abort), 1);
    for (int i = 0; i < 3; i++) step("post_hit", 1'b0, '0, '0);

    // simultaneous hits on cores 3 and 1
    do_reset("reset3");
    step("start", 1'b1, '0, '0);
    for (int i = 0; i < 4; i++) step("fill", 1'b0, '0, '0);
    step("sim_hit", 1'b0, 4'b1010, 4'b1010);
    chk("sim_core", 32'(found_core), 1);
    chk("sim_key", 32'(found_key), 1);

    // spurious done+found on idle core 0 in the first RUN cycle
    do_reset("reset4");
    step("start", 1'b1, '0, '0);
    step("spurious", 1'b0, 4'b0001, 4'b0001);
    chk("spurious_found", 32'(found), 0);
    chk("spurious_dispatch", 32'(core_start), 32'b0001);
    for (int i = 0; i < 4; i++) step("spur_run", 1'b0, '0, '0);

    // randomized searches with hits
    for (int r = 0; r < 6; r++) begin
      do_reset("reset_rand");
      step("start", 1'b1, '0, '0);
      run_random("rand", 4 + 3 * r, 5, 300);
    end

    // 1-core, 22-bit instance: dispatch then reset mid-RUN
    tick_big();
    chk("big_reset_state", 32'(b_dbg_state), ST_IDLE);
    chk("big_reset_keys", 32'(b_keys_issued), 0);
    b_rst = 1'b0; b_start = 1'b1;
    tick_big();
    b_start = 1'b0;
    chk("big_run_busy", 32'(b_busy), 1);
    chk("big_run_nostart", 32'(b_core_start), 0);
    tick_big();
    chk("big_first_start", 32'(b_core_start), 1);
    chk("big_first_key", 32'(b_core_key), 0);
    chk("big_first_keys", 32'(b_keys_issued), 1);
    b_done = 1'b1;
    tick_big();
    b_done = 1'b0;
    chk("big_gap", 32'(b_core_start), 0);
    tick_big();
    chk("big_second_key", 32'(b_core_key), 1);
    chk("big_second_keys", 32'(b_keys_issued), 2);
    b_rst = 1'b1; b_done = 1'b1; b_fnd = 1'b1;
    tick_big();
    b_rst = 1'b0; b_done = 1'b0; b_fnd = 1'b0;
    chk("big_rst_state", 32'(b_dbg_state), ST_IDLE);
    chk("big_rst_start", 32'(b_core_start), 0);
    chk("big_rst_abort", 32'(b_core_abort), 0);
    chk("big_rst_busy", 32'(b_busy), 0);
    chk("big_rst_found", 32'(b_found), 0);
    chk("big_rst_exh", 32'(b_exhausted), 0);
    chk("big_rst_fkey", 32'(b_found_key), 0);
    chk("big_rst_fcore", 32'(b_found_core), 0);
    chk("big_rst_keys", 32'(b_keys_issued), 0);
    chk("big_rst_ckey", 32'(b_core_key), 0);
    b_start = 1'b1;
    tick_big();
    b_start = 1'b0;
    tick_big();
    chk("big_restart_start", 32'(b_core_start), 1);
    chk("big_restart_key", 32'(b_core_key), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
